// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a req/ack handshake per side and a bounded wait that aborts stalled accesses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  bus_err,
  output logic                  sel,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, DONE} state_t;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic                  err_q, err_d;
  logic                  mem_req_q, mem_req_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  grant_dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Acks, bus_err and mem_req are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    mem_req_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm   = dm_req & (~if_req | ~last_q);

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d   = grant_dm ? GNT_DM : GNT_IF;
          sel_d     = grant_dm;
          cnt_d     = '0;
          mem_req_d = 1'b1;
        end
      end
      GNT_IF, GNT_DM: begin
        if (mem_ready) begin
          if (state_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!dm_we) begin
            dm_rdata_d = mem_rdata;
          end
          last_d   = sel_q;
          if_ack_d = ~sel_q;
          dm_ack_d = sel_q;
          state_d  = DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d    = 1'b1;
          last_d   = sel_q;
          if_ack_d = ~sel_q;
          dm_ack_d = sel_q;
          state_d  = DONE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign bus_err   = err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign sel       = sel_q;
  assign mem_req   = mem_req_q;
  assign busy      = busy_q;
  assign mem_addr  = sel_q ? dm_addr : if_addr;
  assign mem_we    = mem_req_q & sel_q & dm_we;
  assign mem_wdata = dm_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven single accesses, arbitration ties and reset abort,
// with a scoreboard queue of expected transactions checked by a memory-side monitor.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int TIMEOUT = 16;
  localparam int NEVER = 1000;

  typedef struct {
    logic          is_dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mdata;
    int            waits;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  logic          clk, reset;
  logic          if_req, if_ack, dm_req, dm_we, dm_ack, bus_err, sel;
  logic          mem_req, mem_we, mem_ready, busy;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;

  int   total;
  int   bad;
  vec_t sb[$];
  vec_t vec[7];

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .bus_err(bus_err), .sel(sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic is_dm, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mdata, input int waits,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.is_dm = is_dm; v.we = we; v.addr = addr; v.wdata = wdata; v.mdata = mdata;
    v.waits = waits; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Memory model plus transaction checker; the front of sb is the access currently expected.
  task automatic monitor();
    int   gcnt;
    vec_t e;
    gcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        gcnt      = 0;
        mem_ready = 1'b0;
      end else begin
        chk("two_acks", 32'(if_ack & dm_ack), 32'd0);
        if (mem_req) begin
          if (sb.size() == 0) begin
            chk("spurious_mem_req", 32'(mem_req), 32'd0);
            mem_ready = 1'b0;
          end else begin
            e = sb[0];
            chk("sel", 32'(sel), 32'(e.is_dm));
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", 32'(mem_we), 32'(e.is_dm & e.we));
            chk("busy_grant", 32'(busy), 32'd1);
            if (e.is_dm && e.we) chk("mem_wdata", mem_wdata, e.wdata);
            mem_ready = (gcnt == e.waits);
            mem_rdata = e.mdata;
            gcnt++;
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = '0;
        end
        if (if_ack || dm_ack) begin
          if (sb.size() == 0) begin
            chk("spurious_ack", 32'(if_ack | dm_ack), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("ack_side_dm", 32'(dm_ack), 32'(e.is_dm));
            chk("ack_side_if", 32'(if_ack), 32'(!e.is_dm));
            chk("rdata", e.is_dm ? dm_rdata : if_rdata, e.exp_rdata);
            chk("bus_err", 32'(bus_err), 32'(e.exp_err));
            chk("grant_cycles", 32'(gcnt), 32'(e.exp_err ? TIMEOUT : e.waits + 1));
            chk("mem_req_in_done", 32'(mem_req), 32'd0);
          end
          gcnt = 0;
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_acks"}, 32'({if_ack, dm_ack}), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
  endtask

  // Single access; drops req at the edge that samples ack and checks req-to-ack latency.
  task automatic do_access(input vec_t v);
    int lat;
    bit seen;
    sb.push_back(v);
    if (v.is_dm) begin
      dm_addr = v.addr; dm_we = v.we; dm_wdata = v.wdata; dm_req = 1'b1;
    end else begin
      if_addr = v.addr; if_req = 1'b1;
    end
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (if_ack || dm_ack) seen = 1'b1;
    end
    chk("ack_latency", 32'(lat), 32'(v.exp_err ? TIMEOUT + 2 : v.waits + 3));
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  // Both requesters held high until n acks have been seen.
  task automatic run_both(input int n);
    int acks;
    acks = 0;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int k = 0; k < 50 * n && acks < n; k++) begin
      @(negedge clk);
      if (if_ack || dm_ack) acks++;
    end
    chk("tie_ack_count", 32'(acks), 32'(n));
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    vec[0] = mk(1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h8C08_0004, 0,     32'h8C08_0004, 1'b0);
    vec[1] = mk(1'b1, 1'b1, 32'h1001_0000, 32'hAABB_CCDD, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
    vec[2] = mk(1'b1, 1'b0, 32'h1001_0004, 32'h0, 32'h0BAD_F00D, NEVER, 32'h0, 1'b1);
    vec[3] = mk(1'b1, 1'b0, 32'h1001_0008, 32'h0, 32'h1234_5678, 0,     32'h1234_5678, 1'b0);
    vec[4] = mk(1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'h2402_0001, 2,     32'h2402_0001, 1'b0);
    vec[5] = mk(1'b0, 1'b0, 32'h0040_0008, 32'h0, 32'h0BAD_CAFE, NEVER, 32'h2402_0001, 1'b1);
    vec[6] = mk(1'b1, 1'b1, 32'h1001_000C, 32'h5566_7788, 32'hFFFF_FFFF, 0, 32'h1234_5678, 1'b0);

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_access(vec[i]);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Tie: last grant was DM, so IF goes first and grants alternate.
    if_addr = 32'h0040_0100; dm_addr = 32'h1001_0100; dm_we = 1'b0; dm_wdata = '0;
    sb.push_back(mk(1'b0, 1'b0, 32'h0040_0100, 32'h0, 32'hA1A1_0001, 0, 32'hA1A1_0001, 1'b0));
    sb.push_back(mk(1'b1, 1'b0, 32'h1001_0100, 32'h0, 32'hA2A2_0002, 0, 32'hA2A2_0002, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 32'h0040_0100, 32'h0, 32'hA3A3_0003, 0, 32'hA3A3_0003, 1'b0));
    sb.push_back(mk(1'b1, 1'b0, 32'h1001_0100, 32'h0, 32'hA4A4_0004, 0, 32'hA4A4_0004, 1'b0));
    run_both(4);
    chk("tie_sb_drained", 32'(sb.size()), 32'd0);

    // Reset during a stalled DM grant abandons it without an ack.
    dm_addr = 32'h1001_0004; dm_we = 1'b0;
    sb.push_back(mk(1'b1, 1'b0, 32'h1001_0004, 32'h0, 32'hCCCC_0000, NEVER, 32'h0, 1'b1));
    dm_req = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    dm_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    repeat (3) begin
      @(negedge clk);
      chk("no_ack_after_reset", 32'({if_ack, dm_ack}), 32'd0);
    end
    @(posedge clk); #1;

    if_addr = 32'h0040_0200;
    sb.push_back(mk(1'b0, 1'b0, 32'h0040_0200, 32'h0, 32'hB1B1_0001, 0, 32'hB1B1_0001, 1'b0));
    sb.push_back(mk(1'b1, 1'b0, 32'h1001_0004, 32'h0, 32'hB2B2_0002, 0, 32'hB2B2_0002, 1'b0));
    run_both(2);
    chk("post_reset_sb_drained", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and data access (DM).
- Runs a request/acknowledge handshake with each requester and picks a winner by round-robin on ties.
- Drives the selector of the 32-bit 2:1 address/data mux in front of the memory.
- Aborts a stalled access with an error after a bounded number of wait cycles.

Parameters:
- ADDR_WIDTH, 32, width of addresses.
- DATA_WIDTH, 32, width of read/write data.
- TIMEOUT, 16, maximum cycles spent in a grant state without mem_ready before abort (>=2).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- if_req  in  1  fetch request, held high until if_ack sampled
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_ack  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DATA_WIDTH  fetched word, registered, valid when if_ack
- dm_req  in  1  data request, held high until dm_ack sampled
- dm_we  in  1  1 = store, 0 = load; stable while dm_req
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_ack  out  1  one-cycle completion pulse to data side
- dm_rdata  out  DATA_WIDTH  load word, registered, valid when dm_ack
- bus_err  out  1  high with if_ack/dm_ack when the access timed out
- sel  out  1  mux selector: 0 = IF path, 1 = DM path
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address (mux of if_addr/dm_addr by sel)
- mem_wdata  out  DATA_WIDTH  dm_wdata passthrough
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the access this cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; if_ack, dm_ack, bus_err, mem_req, mem_we, sel = 0; if_rdata = dm_rdata = 0; wait counter = 0; last_grant = 1 (DM), so the first tie goes to IF.
- Reset mid-access abandons the transaction. No ack is issued. Reset has priority over every other event.
- States: IDLE, GNT_IF, GNT_DM, DONE.
- IDLE transitions:
  - only if_req: go to GNT_IF, sel<=0.
  - only dm_req: go to GNT_DM, sel<=1.
  - both: grant the side opposite last_grant.
  - none: stay in IDLE.
  - wait counter <= 0 on every grant.
- GNT_x outputs and exit:
  - mem_req=1; mem_addr = sel ? dm_addr : if_addr; mem_we = sel & dm_we; mem_wdata = dm_wdata.
  - mem_ready=1: capture mem_rdata into x_rdata (loads/fetches only; stores leave dm_rdata unchanged), bus_err<=0, last_grant<=sel, go to DONE.
  - mem_ready=0 with counter = TIMEOUT-1: x_rdata unchanged, bus_err<=1, last_grant<=sel, go to DONE.
  - otherwise counter increments.
- DONE: the granted side's ack=1 for exactly this cycle, bus_err valid, mem_req=0. Always go to IDLE next.
- Requester contract: deassert req at the edge where ack=1 is sampled. A request held high afterwards is treated as a new request.
- Latency: with zero-wait memory (mem_ready in first grant cycle), req sampled at edge N gives ack in cycle N+2; next arbitration in cycle N+3.
- A requester that drops req while granted is not supported. The access completes regardless.
- sel holds its value in IDLE and DONE; it changes only on a grant.
- mem_req never high in IDLE or DONE. Only one ack is high in any cycle.

Test Plan:
- Reset then if_req=1, if_addr=0x00400000, mem_ready=1 same cycle, mem_rdata=0x8C080004: expect sel=0, mem_req one cycle, if_ack pulse 2 cycles after req, if_rdata=0x8C080004, bus_err=0.
- dm_req=1, dm_we=1, dm_addr=0x10010000, dm_wdata=0xAABBCCDD, mem_ready after 3 wait cycles: expect sel=1, mem_we=1 for 4 cycles, mem_addr=0x10010000, dm_ack once, dm_rdata unchanged.
- if_req and dm_req held high together for 4 transactions, zero-wait memory: grants alternate IF, DM, IF, DM; never two acks in one cycle.
- dm_req load to 0x10010004 with mem_ready tied 0: expect abort after exactly 16 grant cycles, dm_ack=1 with bus_err=1, dm_rdata unchanged; next access with mem_ready=1 gives bus_err=0.
- Assert reset for one cycle during GNT_DM wait: expect IDLE next cycle, mem_req=0, no ack, outputs at reset values; following IF request then wins a tie with dm_req.
